// File: rtl/fft8_bitrev_loader.sv
// Input stage of the 8-point FFT: loads a frame in natural order at bit-reversed slots, then streams stage-1 butterfly pairs.
// Optional input conjugation for IFFT-via-FFT is enabled by defining FFT8_IFFT_CONJ_EN (adds the 'inverse' port).
module fft8_bitrev_loader #(
  parameter int WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
`ifdef FFT8_IFFT_CONJ_EN
  input  logic                    inverse,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_a_re,
  output logic signed [WIDTH-1:0] out_a_im,
  output logic signed [WIDTH-1:0] out_b_re,
  output logic signed [WIDTH-1:0] out_b_im,
  output logic                    out_first,
  output logic                    out_last
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [2:0]           wr_cnt;
  logic [1:0]           rd_cnt;
  logic [2*WIDTH-1:0]   mem [8];
  logic                 wr_en;
  logic                 rd_adv;
  logic [WIDTH-1:0]     store_im;
  logic [2*WIDTH-1:0]   a_word;
  logic [2*WIDTH-1:0]   b_word;

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

`ifdef FFT8_IFFT_CONJ_EN
  // The most negative value has no positive twin; clamp it to the largest positive one.
  function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] most_neg;
    most_neg = {1'b1, {(WIDTH-1){1'b0}}};
    if (v == most_neg) return {1'b0, {(WIDTH-1){1'b1}}};
    return ~v + 1'b1;
  endfunction

  assign store_im = inverse ? sat_neg(in_im) : in_im;
`else
  assign store_im = in_im;
`endif

  assign wr_en  = in_valid  & in_ready;
  assign rd_adv = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // NOTE: a default assignment ahead of the case keeps this combinational block free of latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (wr_en  && (wr_cnt == 3'd7)) state_d = DRAIN;
      DRAIN:   if (rd_adv && (rd_cnt == 2'd3)) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == DRAIN);
    out_first = out_valid && (rd_cnt == 2'd0);
    out_last  = out_valid && (rd_cnt == 2'd3);
    out_a_re  = '0;
    out_a_im  = '0;
    out_b_re  = '0;
    out_b_im  = '0;
    if (out_valid) begin
      out_a_re = a_word[2*WIDTH-1:WIDTH];
      out_a_im = a_word[WIDTH-1:0];
      out_b_re = b_word[2*WIDTH-1:WIDTH];
      out_b_im = b_word[WIDTH-1:0];
    end
  end

  // Counters wrap naturally at 8 samples and 4 pairs, which ends each phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_en)  wr_cnt <= wr_cnt + 3'd1;
      if (rd_adv) rd_cnt <= rd_cnt + 2'd1;
    end
  end

  // NOTE: the frame buffer is deliberately not reset; a fresh frame overwrites every slot before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[bitrev3(wr_cnt)] <= {in_re, store_im};
  end

  assign a_word = mem[{rd_cnt, 1'b0}];
  assign b_word = mem[{rd_cnt, 1'b1}];

endmodule

// File: tb/tb_fft8_bitrev_loader.sv
// Randomized self-checking bench for fft8_bitrev_loader against a natural-order frame model.
// Conjugation tests are compiled in when FFT8_IFFT_CONJ_EN is defined.
module tb_fft8_bitrev_loader;

  localparam int W = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                inv;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_a_re, out_a_im, out_b_re, out_b_im;
  logic                out_first, out_last;

  always #5 clk = ~clk;

  fft8_bitrev_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
`ifdef FFT8_IFFT_CONJ_EN
    .inverse   (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a_re  (out_a_re),
    .out_a_im  (out_a_im),
    .out_b_re  (out_b_re),
    .out_b_im  (out_b_im),
    .out_first (out_first),
    .out_last  (out_last)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle", tag, got, exp);
    end
  endtask

  // Reference model: frame kept in natural sample order; pair p holds samples ord[p] and ord[p]+4.
  int mx_re [8];
  int mx_im [8];
  int m_cnt;
  int m_p;
  bit m_fill;
  int ord [4] = '{0, 2, 1, 3};

  int  cyc = 0;
  int  last_first_cyc = -1;
  bit  period_on = 1'b0;
  int  cur_re, cur_im;

  function automatic int sat_neg(input int v);
    if (v == -(1 << (W-1))) return (1 << (W-1)) - 1;
    return -v;
  endfunction

  function automatic int sx(input int v);
    logic [W-1:0] t;
    t = W'(v);
    return int'($signed(t));
  endfunction

  function automatic logic [4*W-1:0] pack(input int ar, input int ai, input int br, input int bi);
    return {W'(ar), W'(ai), W'(br), W'(bi)};
  endfunction

  task automatic model_reset();
    m_fill = 1'b1;
    m_cnt  = 0;
    m_p    = 0;
  endtask

  task automatic new_sample();
    cur_re = sx(int'($urandom_range(0, (1 << W) - 1)));
    cur_im = sx(int'($urandom_range(0, (1 << W) - 1)));
  endtask

  task automatic run_cycle(input bit r, input bit v, input int re, input int im,
                           input bit iv, input bit rdy, output bit accepted);
    logic [4*W-1:0] exp;
    rst = r; in_valid = v; in_re = W'(re); in_im = W'(im); inv = iv; out_ready = rdy;
    @(negedge clk);
    check("in_ready", in_ready, m_fill);
    check("out_valid", out_valid, !m_fill);
    exp = '0;
    if (!m_fill)
      exp = pack(mx_re[ord[m_p]], mx_im[ord[m_p]], mx_re[ord[m_p]+4], mx_im[ord[m_p]+4]);
    check("pair_data", {out_a_re, out_a_im, out_b_re, out_b_im}, exp);
    check("out_first", out_first, !m_fill && (m_p == 0));
    check("out_last", out_last, !m_fill && (m_p == 3));
    if (period_on && out_first && rdy) begin
      if (last_first_cyc >= 0) check("frame_period", cyc - last_first_cyc, 12);
      last_first_cyc = cyc;
    end
    accepted = 1'b0;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (m_fill) begin
      if (v) begin
        accepted = 1'b1;
        mx_re[m_cnt] = sx(re);
`ifdef FFT8_IFFT_CONJ_EN
        mx_im[m_cnt] = iv ? sat_neg(sx(im)) : sx(im);
`else
        mx_im[m_cnt] = sx(im);
`endif
        m_cnt++;
        if (m_cnt == 8) begin m_cnt = 0; m_fill = 1'b0; end
      end
    end else if (rdy) begin
      m_p++;
      if (m_p == 4) begin m_p = 0; m_fill = 1'b1; end
    end
    #1;
    cyc++;
  endtask

  // Held-sample source: the upstream value only changes once it has been consumed.
  task automatic stream(input bit v, input bit rdy, input bit iv);
    bit acc;
    run_cycle(1'b0, v, cur_re, cur_im, iv, rdy, acc);
    if (acc) new_sample();
  endtask

  task automatic random_frame();
    for (int i = 0; i < 8; i++) stream(1'b1, 1'b1, 1'b0);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 4; i++) stream(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bit acc;
    int re_tab [8] = '{0, 1, -2, -1, 0, 1, -2, -1};
    int im_tab [8] = '{-2, -1, 0, 1, -2, -1, 0, 1};

    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; inv = 1'b0; out_ready = 1'b0;
    model_reset();
    new_sample();
    repeat (2) @(posedge clk);
    #1;

    // Reset state with idle inputs.
    run_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, acc);

    // Natural-order directed frame.
    for (int n = 0; n < 8; n++) run_cycle(1'b0, 1'b1, re_tab[n], n % 4, 1'b0, 1'b1, acc);
    drain_all();

    // Backpressure on pair 1 with ignored input pulses.
    random_frame();
    stream(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) stream(i[0] == 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) stream(1'b1, 1'b1, 1'b0);

    // Back-to-back frames at full rate.
    period_on = 1'b1;
    last_first_cyc = -1;
    for (int i = 0; i < 36; i++) stream(1'b1, 1'b1, 1'b0);
    period_on = 1'b0;

    // Gapped input.
    for (int i = 0; i < 16; i++) stream(i[0] == 1'b0, 1'b1, 1'b0);
    drain_all();

    // Reset after five samples, then a clean frame.
    for (int i = 0; i < 5; i++) stream(1'b1, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b1, cur_re, cur_im, 1'b0, 1'b1, acc);
    stream(1'b0, 1'b1, 1'b0);
    random_frame();
    drain_all();

    // Random valid/ready traffic with rare resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        run_cycle(1'b1, 1'b0, cur_re, cur_im, 1'b0, 1'b0, acc);
      end else begin
        stream(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
    end

`ifdef FFT8_IFFT_CONJ_EN
    // Flush to FILL, then directed conjugation and bit-exact frames.
    run_cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, acc);
    for (int n = 0; n < 8; n++) run_cycle(1'b0, 1'b1, re_tab[n], im_tab[n], 1'b1, 1'b1, acc);
    drain_all();
    for (int n = 0; n < 8; n++) run_cycle(1'b0, 1'b1, re_tab[n], im_tab[n], 1'b0, 1'b1, acc);
    drain_all();
    for (int i = 0; i < 200; i++) begin
      bit iv;
      iv = 1'($urandom_range(0, 1));
      stream(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), iv);
    end
`else
    for (int n = 0; n < 8; n++) run_cycle(1'b0, 1'b1, re_tab[n], im_tab[n], 1'b0, 1'b1, acc);
    drain_all();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
